// File: rtl/qam_pkg.sv
// Shared definitions for the QAM bit scheduler: modulation encodings,
// the bits-per-symbol mapping and the scheduler FSM state encodings.
package qam_pkg;

    // Widest symbol (64-QAM) and the width of the inter-request gap counter.
    localparam int SYM_W = 6;
    localparam int GAP_W = 8;

    // qam_mode encodings.
    localparam logic [1:0] MODE_QPSK  = 2'b00;
    localparam logic [1:0] MODE_QAM16 = 2'b01;
    localparam logic [1:0] MODE_QAM64 = 2'b10;
    localparam logic [1:0] MODE_RSVD  = 2'b11;

    // Scheduler FSM states.
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_GAP  = 3'd1;
    localparam logic [2:0] ST_REQ  = 3'd2;
    localparam logic [2:0] ST_CAP  = 3'd3;
    localparam logic [2:0] ST_OUT  = 3'd4;

    // Bits carried by one symbol; the reserved code falls back to QPSK.
    function automatic logic [2:0] bits_per_mode(input logic [1:0] mode);
        case (mode)
            MODE_QAM16: return 3'd4;
            MODE_QAM64: return 3'd6;
            default:    return 3'd2;
        endcase
    endfunction

endpackage

// File: rtl/qam_req_pacer.sv
// Gap timer: after a start pulse, done rises on the REQ_GAP-th cycle so the
// scheduler spends exactly REQ_GAP cycles idling before each bit request.
module qam_req_pacer
    import qam_pkg::*;
#(
    parameter int REQ_GAP = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic done
);

    // The cycle after start is the first gap cycle, so load one less than the gap.
    localparam logic [GAP_W-1:0] LOAD = GAP_W'(REQ_GAP - 1);

    logic [GAP_W-1:0] cnt;

    // Down-counter, reloaded on start and parked at zero once expired.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= LOAD;
        end else if (cnt != '0) begin
            cnt <= cnt - GAP_W'(1);
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/qam_bit_sched.sv
// QAM bit scheduler: paces single-bit requests to an m-sequence generator,
// assembles 2/4/6-bit symbols MSB-first and hands them to the mapper over a
// valid/ready handshake, counting accepted symbols.
module qam_bit_sched
    import qam_pkg::*;
#(
    parameter int REQ_GAP = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       qam_mode,
    output logic             gen_bit_req,
    input  logic             m_seq_out,
    output logic [SYM_W-1:0] sym_data,
    output logic [1:0]       sym_mode,
    output logic             sym_valid,
    input  logic             sym_ready,
    output logic [CNT_W-1:0] sym_cnt
);

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [2:0]       bit_cnt;
    logic [SYM_W-1:0] shreg;
    logic             gap_start;
    logic             gap_done;
    logic             last_bit;
    logic             handshake;

    assign handshake = (state == ST_OUT) && sym_ready;
    // The bit being captured this cycle completes the symbol.
    assign last_bit  = (3'(bit_cnt + 3'd1) == bits_per_mode(sym_mode));

    // Next-state selection for the request/capture/present loop.
    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch is inferred.
        state_nxt = state;
        case (state)
            ST_IDLE: if (en) state_nxt = ST_GAP;
            ST_GAP: begin
                if (!en)          state_nxt = ST_IDLE;
                else if (gap_done) state_nxt = ST_REQ;
            end
            ST_REQ:  state_nxt = ST_CAP;
            ST_CAP: begin
                if (!en)          state_nxt = ST_IDLE;
                else if (last_bit) state_nxt = ST_OUT;
                else              state_nxt = ST_GAP;
            end
            ST_OUT:  if (sym_ready) state_nxt = en ? ST_GAP : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Every entry into GAP restarts the gap timer.
    assign gap_start = (state_nxt == ST_GAP) && (state != ST_GAP);

    qam_req_pacer #(
        .REQ_GAP(REQ_GAP)
    ) u_pacer (
        .clk  (clk),
        .rst_n(rst_n),
        .start(gap_start),
        .done (gap_done)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Symbol assembly: mode latch, bit counter and MSB-first shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sym_mode <= MODE_QPSK;
            bit_cnt  <= '0;
            shreg    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (en) begin
                        sym_mode <= qam_mode;
                        bit_cnt  <= '0;
                        shreg    <= '0;
                    end
                end
                ST_CAP: begin
                    if (!en) begin
                        // Abort: the partial symbol is dropped.
                        bit_cnt <= '0;
                        shreg   <= '0;
                    end else begin
                        shreg   <= {shreg[SYM_W-2:0], m_seq_out};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                end
                ST_OUT: begin
                    if (sym_ready) begin
                        // Symbol accepted: start afresh with the current mode.
                        sym_mode <= qam_mode;
                        bit_cnt  <= '0;
                        shreg    <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Accepted-symbol counter, wrapping naturally at its width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         sym_cnt <= '0;
        else if (handshake) sym_cnt <= sym_cnt + CNT_W'(1);
    end

    assign gen_bit_req = (state == ST_REQ);
    assign sym_valid   = (state == ST_OUT);
    assign sym_data    = sym_valid ? shreg : '0;

endmodule

// File: tb/tb_qam_bit_sched.sv
// Self-checking bench for qam_bit_sched: a table of single symbols, directed
// corner sequences (reset, back-pressure, abort, mode change, wrap, reset in
// OUT) and a randomized run against a transaction-level model.
module tb_qam_bit_sched;

    localparam int GAP = 4;
    localparam int CW  = 4;
    localparam int BIT_COST = GAP + 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic [1:0]    qam_mode = 2'b00;
    logic          m_seq_out = 1'b0;
    logic          sym_ready = 1'b0;
    logic          gen_bit_req;
    logic [5:0]    sym_data;
    logic [1:0]    sym_mode;
    logic          sym_valid;
    logic [CW-1:0] sym_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int viol = 0;
    int req_total = 0;
    int exp_cnt = 0;
    bit bit_q[$];
    bit dlv_q[$];

    typedef struct {
        logic [1:0] mode;
        logic [5:0] bits;      // bit sequence, first bit at [5]
        logic [5:0] exp_data;  // right-aligned expected symbol
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    qam_bit_sched #(
        .REQ_GAP(GAP),
        .CNT_W  (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .qam_mode   (qam_mode),
        .gen_bit_req(gen_bit_req),
        .m_seq_out  (m_seq_out),
        .sym_data   (sym_data),
        .sym_mode   (sym_mode),
        .sym_valid  (sym_valid),
        .sym_ready  (sym_ready),
        .sym_cnt    (sym_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int n_of(input logic [1:0] m);
        return (m == 2'b01) ? 4 : ((m == 2'b10) ? 6 : 2);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Weighted sum of the next n delivered bits: the first bit weighs 2^(n-1).
    task automatic take_bits(input int n, output logic [5:0] d);
        d = '0;
        for (int i = 0; i < n; i++) begin
            if (dlv_q.size() > 0) begin
                if (dlv_q.pop_front()) d = d + 6'(1 << (n - 1 - i));
            end
        end
    endtask

    task automatic wait_valid(input int limit, output int edges);
        edges = 0;
        while (!sym_valid && edges < limit) begin
            tick();
            edges++;
        end
        if (!sym_valid) check("valid_timeout", 32'(sym_valid), 32'd1);
    endtask

    task automatic accept(input logic en_after);
        sym_ready = 1'b1;
        en = en_after;
        tick();
        sym_ready = 1'b0;
        exp_cnt = (exp_cnt + 1) % (1 << CW);
        check("acc_cnt", 32'(sym_cnt), 32'(exp_cnt));
        check("acc_valid_low", 32'(sym_valid), 32'd0);
    endtask

    // Generator model: answers each request with a bit on the following cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (gen_bit_req === 1'b1) begin
                @(posedge clk);
                #1;
                if (bit_q.size() > 0) m_seq_out = bit_q.pop_front();
                else                  m_seq_out = 1'($urandom_range(0, 1));
                dlv_q.push_back(m_seq_out);
            end
        end
    end

    // Protocol monitor: no back-to-back requests and no request while presenting.
    initial begin
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (gen_bit_req === 1'b1) begin
                req_total++;
                if (prev || sym_valid) viol++;
            end
            prev = gen_bit_req;
        end
    end

    initial begin
        int          edges;
        int          base;
        int          nreq;
        int          bad;
        int          since;
        logic        hs;
        logic        prev_valid;
        logic [1:0]  lat;
        logic [1:0]  nlat;
        logic [5:0]  prev_data;
        logic [5:0]  d;

        vecs[0] = '{2'b00, 6'b100000, 6'b000010};
        vecs[1] = '{2'b00, 6'b010000, 6'b000001};
        vecs[2] = '{2'b01, 6'b110100, 6'b001101};
        vecs[3] = '{2'b01, 6'b011000, 6'b000110};
        vecs[4] = '{2'b10, 6'b101101, 6'b101101};
        vecs[5] = '{2'b10, 6'b010011, 6'b010011};
        vecs[6] = '{2'b11, 6'b110000, 6'b000011};
        vecs[7] = '{2'b11, 6'b011111, 6'b000001};

        // Reset held 25 cycles with en low.
        rst_n = 1'b0;
        repeat (25) tick();
        check("rst_valid", 32'(sym_valid), 32'd0);
        check("rst_data", 32'(sym_data), 32'd0);
        check("rst_mode", 32'(sym_mode), 32'd0);
        check("rst_cnt", 32'(sym_cnt), 32'd0);
        check("rst_req", 32'(gen_bit_req), 32'd0);
        rst_n = 1'b1;
        repeat (5) tick();
        check("idle_reqs", 32'(req_total), 32'd0);
        check("idle_valid", 32'(sym_valid), 32'd0);

        // Table of single symbols, each started from IDLE.
        for (int v = 0; v < 8; v++) begin
            qam_mode = vecs[v].mode;
            for (int i = 0; i < n_of(vecs[v].mode); i++) bit_q.push_back(vecs[v].bits[5 - i]);
            en = 1'b1;
            wait_valid(200, edges);
            // One edge to leave IDLE, then N bits at GAP+2 cycles each.
            check("vec_latency", 32'(edges), 32'(1 + n_of(vecs[v].mode) * BIT_COST));
            check("vec_data", 32'(sym_data), 32'(vecs[v].exp_data));
            check("vec_mode", 32'(sym_mode), 32'(vecs[v].mode));
            accept(1'b0);
        end
        dlv_q.delete();

        // 64-QAM back-pressure: 20 stalled cycles, en dropped half-way through.
        qam_mode = 2'b10;
        bit_q = '{1, 0, 1, 1, 0, 1};
        en = 1'b1;
        wait_valid(200, edges);
        check("bp_data", 32'(sym_data), 32'h2d);
        base = req_total;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 10) en = 1'b0;
            tick();
            if (sym_valid !== 1'b1 || sym_data !== 6'b101101 || sym_mode !== 2'b10) bad++;
        end
        check("bp_stable", 32'(bad), 32'd0);
        check("bp_no_req", 32'(req_total), 32'(base));
        check("bp_cnt_hold", 32'(sym_cnt), 32'(exp_cnt));
        accept(1'b0);
        dlv_q.delete();

        // Abort after 3 of 4 bits in 16-QAM, then a fresh symbol.
        qam_mode = 2'b01;
        bit_q = '{1, 1, 1};
        en = 1'b1;
        nreq = 0;
        edges = 0;
        while (nreq < 3 && edges < 200) begin
            tick();
            edges++;
            if (gen_bit_req) nreq++;
        end
        check("abort_reqs", 32'(nreq), 32'd3);
        tick();
        tick();
        en = 1'b0;
        base = req_total;
        bad = 0;
        repeat (30) begin
            tick();
            if (sym_valid) bad++;
        end
        check("abort_no_valid", 32'(bad), 32'd0);
        check("abort_no_req", 32'(req_total), 32'(base));
        dlv_q.delete();
        bit_q = '{0, 1, 0, 1};
        en = 1'b1;
        wait_valid(200, edges);
        check("abort_fresh_lat", 32'(edges), 32'(1 + 4 * BIT_COST));
        check("abort_fresh_data", 32'(sym_data), 32'h05);
        check("abort_fresh_mode", 32'(sym_mode), 32'd1);
        accept(1'b0);
        dlv_q.delete();

        // Mode change mid-symbol takes effect only after the handshake.
        qam_mode = 2'b01;
        bit_q = '{1, 0, 0, 1, 1, 1, 0, 0, 1, 0};
        en = 1'b1;
        edges = 0;
        while (!gen_bit_req && edges < 50) begin
            tick();
            edges++;
        end
        qam_mode = 2'b10;
        wait_valid(200, edges);
        check("mc_first_data", 32'(sym_data), 32'h09);
        check("mc_first_mode", 32'(sym_mode), 32'd1);
        accept(1'b1);
        wait_valid(200, edges);
        check("mc_second_lat", 32'(edges), 32'(6 * BIT_COST));
        check("mc_second_data", 32'(sym_data), 32'h32);
        check("mc_second_mode", 32'(sym_mode), 32'd2);
        accept(1'b0);
        dlv_q.delete();

        // Counter wrap: 16 accepted symbols bring sym_cnt back to 0.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_cnt = 0;
        tick();
        qam_mode = 2'b00;
        en = 1'b1;
        for (int s = 0; s < 16; s++) begin
            wait_valid(200, edges);
            accept(1'b1);
        end
        en = 1'b0;
        tick();
        check("wrap_zero", 32'(sym_cnt), 32'd0);
        dlv_q.delete();

        // Reset asserted while presenting a symbol clears outputs at once.
        qam_mode = 2'b10;
        en = 1'b1;
        wait_valid(200, edges);
        accept(1'b1);
        wait_valid(200, edges);
        rst_n = 1'b0;
        #1;
        check("rout_valid", 32'(sym_valid), 32'd0);
        check("rout_cnt", 32'(sym_cnt), 32'd0);
        check("rout_data", 32'(sym_data), 32'd0);
        check("rout_mode", 32'(sym_mode), 32'd0);
        exp_cnt = 0;
        en = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        base = req_total;
        repeat (20) tick();
        check("rout_no_req", 32'(req_total), 32'(base));
        check("rout_idle_valid", 32'(sym_valid), 32'd0);
        bit_q.delete();
        dlv_q.delete();

        // Randomized run: random modes and ready against the symbol-level model.
        qam_mode = 2'($urandom_range(0, 3));
        lat = qam_mode;
        en = 1'b1;
        tick();
        since = 0;
        prev_valid = sym_valid;
        bad = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 7) == 0) qam_mode = 2'($urandom_range(0, 3));
            sym_ready = ($urandom_range(0, 2) != 0);
            hs = sym_valid && sym_ready;
            nlat = qam_mode;
            prev_data = sym_data;
            tick();
            if (hs) begin
                since = 0;
                lat = nlat;
                exp_cnt = (exp_cnt + 1) % (1 << CW);
                check("rnd_cnt", 32'(sym_cnt), 32'(exp_cnt));
            end else begin
                since++;
                if (sym_valid && !prev_valid) begin
                    check("rnd_latency", 32'(since), 32'(n_of(lat) * BIT_COST));
                    check("rnd_mode", 32'(sym_mode), 32'(lat));
                    take_bits(n_of(lat), d);
                    check("rnd_data", 32'(sym_data), 32'(d));
                end else if (sym_valid && prev_valid && sym_data !== prev_data) begin
                    bad++;
                end
            end
            prev_valid = sym_valid;
        end
        check("rnd_stable", 32'(bad), 32'd0);
        en = 1'b0;
        sym_ready = 1'b1;
        repeat (5) tick();
        sym_ready = 1'b0;

        check("protocol", 32'(viol), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
